// File: rtl/ksa_pulse_result_checker.sv
// Receive-side checker for the KSA4 pulse-stimulus harness.
// Delays a+b+cin by LATENCY windows and scores the captured {cout,sum}.
module ksa_pulse_result_checker #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 4,
    parameter int NUM_VEC = 12,
    parameter int CNT_W   = 16
) (
    input  logic             GCLK_Pad,
    input  logic             rstn_Pad,
    input  logic             start_Pad,
    input  logic [WIDTH-1:0] a_Pad,
    input  logic [WIDTH-1:0] b_Pad,
    input  logic             cin_Pad,
    input  logic [WIDTH-1:0] sum_Pad,
    input  logic             cout_Pad,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH:0]   first_err_exp,
    output logic [WIDTH:0]   first_err_got
);

    localparam int RW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

    state_t           state, state_n;
    logic [RW-1:0]    chain [LATENCY];
    logic [LATENCY-1:0] vld;
    logic [3:0]       fill_cnt, fill_cnt_n;
    logic [RW-1:0]    exp_now, got, head;
    logic             start_go, load;

    logic             busy_n, done_n, pass_n;
    logic [CNT_W-1:0] vec_n, err_n, idx_n;
    logic [RW-1:0]    fexp_n, fgot_n;

    assign exp_now  = RW'(a_Pad) + RW'(b_Pad) + RW'(cin_Pad);
    assign got      = {cout_Pad, sum_Pad};
    assign head     = chain[LATENCY-1];
    assign start_go = start_Pad && (state == IDLE || state == DONE);
    // the start window itself carries operand 0
    assign load     = start_go || state == FILL || state == CHECK;

    always_comb begin
        state_n    = state;
        fill_cnt_n = fill_cnt;
        busy_n     = busy;
        done_n     = done;
        pass_n     = pass;
        vec_n      = vec_cnt;
        err_n      = err_cnt;
        idx_n      = first_err_idx;
        fexp_n     = first_err_exp;
        fgot_n     = first_err_got;
        unique case (state)
            IDLE, DONE: begin
                if (start_Pad) begin
                    state_n    = (LATENCY == 1) ? CHECK : FILL;
                    fill_cnt_n = '0;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    pass_n     = 1'b0;
                    vec_n      = '0;
                    err_n      = '0;
                    idx_n      = '0;
                    fexp_n     = '0;
                    fgot_n     = '0;
                end
            end
            FILL: begin
                if (int'(fill_cnt) >= LATENCY - 2) state_n = CHECK;
                else fill_cnt_n = fill_cnt + 4'd1;
            end
            CHECK: begin
                if (vld[LATENCY-1]) begin
                    vec_n = vec_cnt + CNT_W'(1);
                    if (got != head) begin
                        if (err_cnt == '0) begin
                            idx_n  = vec_cnt;
                            fexp_n = head;
                            fgot_n = got;
                        end
                        if (~&err_cnt) err_n = err_cnt + CNT_W'(1);
                    end
                    if (vec_cnt == CNT_W'(NUM_VEC - 1)) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == '0);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge GCLK_Pad or negedge rstn_Pad) begin
        if (!rstn_Pad) begin
            state         <= IDLE;
            fill_cnt      <= '0;
            vld           <= '0;
            for (int i = 0; i < LATENCY; i++) chain[i] <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            state         <= state_n;
            fill_cnt      <= fill_cnt_n;
            chain[0]      <= exp_now;
            vld[0]        <= load;
            for (int i = 1; i < LATENCY; i++) begin
                chain[i] <= chain[i-1];
                vld[i]   <= vld[i-1];
            end
            busy          <= busy_n;
            done          <= done_n;
            pass          <= pass_n;
            vec_cnt       <= vec_n;
            err_cnt       <= err_n;
            first_err_idx <= idx_n;
            first_err_exp <= fexp_n;
            first_err_got <= fgot_n;
        end
    end

endmodule

// File: tb/tb_ksa_pulse_result_checker.sv
// Bench for ksa_pulse_result_checker: LATENCY=4 instance plus a LATENCY=1 one.
// Adder results and run summaries are modelled with scoreboard queues.
module tb_ksa_pulse_result_checker;

    localparam int L = 4;
    localparam int N = 12;

    logic clk = 0;
    logic rstn = 0;
    logic start = 0, start1 = 0;
    logic [3:0] a = 0, b = 0, sum = 0, sum1 = 0;
    logic cin = 0, cout = 0, cout1 = 0;

    logic busy, done, pass;
    logic [15:0] vec_cnt, err_cnt, fidx;
    logic [4:0] fexp, fgot;
    logic busy1, done1, pass1;
    logic [15:0] vec1, err1, fidx1;
    logic [4:0] fexp1, fgot1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        pass;
        logic [15:0] vec;
        logic [15:0] err;
        logic [15:0] idx;
        logic [4:0]  fexp;
        logic [4:0]  fgot;
    } sum_t;

    sum_t        sb[$];
    logic [4:0]  res_q[$];

    always #5 clk = ~clk;

    ksa_pulse_result_checker #(.WIDTH(4), .LATENCY(L), .NUM_VEC(N), .CNT_W(16)) dut (
        .GCLK_Pad(clk), .rstn_Pad(rstn), .start_Pad(start),
        .a_Pad(a), .b_Pad(b), .cin_Pad(cin), .sum_Pad(sum), .cout_Pad(cout),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .first_err_idx(fidx),
        .first_err_exp(fexp), .first_err_got(fgot)
    );

    ksa_pulse_result_checker #(.WIDTH(4), .LATENCY(1), .NUM_VEC(1), .CNT_W(16)) dut1 (
        .GCLK_Pad(clk), .rstn_Pad(rstn), .start_Pad(start1),
        .a_Pad(a), .b_Pad(b), .cin_Pad(cin), .sum_Pad(sum1), .cout_Pad(cout1),
        .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vec1),
        .err_cnt(err1), .first_err_idx(fidx1),
        .first_err_exp(fexp1), .first_err_got(fgot1)
    );

    // One LATENCY=4 run; returns early (reset held) when rst_win is hit.
    task automatic run4(input int fault_idx, input logic [4:0] mask,
                        input bit zero, input bit restarts, input int rst_win);
        sum_t e;
        sum_t o;
        logic [4:0] r, g;
        bit first;
        e = '{pass: 1'b0, vec: 16'd12, err: 16'd0, idx: 16'd0,
              fexp: 5'd0, fgot: 5'd0};
        first = 1;
        res_q.delete();
        for (int t = 0; t < L + N; t++) begin
            @(negedge clk);
            if (t == 1) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_in_fill got %b exp 1", busy);
                end
            end
            if (t == L + N - 1) begin
                tests++;
                if (done !== 1'b0) begin
                    fails++;
                    $display("FAIL done_early got %b exp 0", done);
                end
            end
            if (t == rst_win) begin
                tests++;
                if (vec_cnt !== 16'(t - L) || err_cnt !== 16'd1) begin
                    fails++;
                    $display("FAIL pre_reset vec %0d err %0d exp %0d 1",
                             vec_cnt, err_cnt, t - L);
                end
                #1 rstn = 0;
                #1;
                tests++;
                if ({busy, done, pass, vec_cnt, err_cnt, fidx, fexp, fgot} !== '0) begin
                    fails++;
                    $display("FAIL async_reset busy %b done %b vec %0d err %0d idx %0d exp all 0",
                             busy, done, vec_cnt, err_cnt, fidx);
                end
                start = 0;
                return;
            end
            start = (t == 0) || (restarts && (t == 1 || t == L + 2));
            if (t < N) begin
                if (zero) begin
                    a = 0; b = 0; cin = 0;
                end else if (t == 0) begin
                    a = 4'b0011; b = 4'b1110; cin = 1;
                end else if (t == fault_idx) begin
                    a = 4'd1; b = 4'd2; cin = 0;
                end else begin
                    a = 4'($urandom_range(15));
                    b = 4'($urandom_range(15));
                    cin = 1'($urandom_range(1));
                end
                res_q.push_back(5'(a) + 5'(b) + 5'(cin));
            end else begin
                a = 4'($urandom_range(15));
                b = 4'($urandom_range(15));
                cin = 1'($urandom_range(1));
            end
            if (t >= L) begin
                r = res_q.pop_front();
                g = (t - L == fault_idx) ? (r ^ mask) : r;
                if (g != r) begin
                    e.err++;
                    if (first) begin
                        first = 0;
                        e.idx = 16'(t - L);
                        e.fexp = r;
                        e.fgot = g;
                    end
                end
                {cout, sum} = g;
            end else begin
                {cout, sum} = 5'd0;
            end
        end
        e.pass = (e.err == 0);
        sb.push_back(e);
        @(negedge clk);
        start = 0;
        {cout, sum} = 5'd0;
        o = sb.pop_front();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_on_time got %b exp 1", done);
        end
        tests++;
        if (pass !== o.pass) begin
            fails++;
            $display("FAIL pass got %b exp %b", pass, o.pass);
        end
        tests++;
        if (vec_cnt !== o.vec) begin
            fails++;
            $display("FAIL vec_cnt got %0d exp %0d", vec_cnt, o.vec);
        end
        tests++;
        if (err_cnt !== o.err) begin
            fails++;
            $display("FAIL err_cnt got %0d exp %0d", err_cnt, o.err);
        end
        tests++;
        if (fidx !== o.idx || fexp !== o.fexp || fgot !== o.fgot) begin
            fails++;
            $display("FAIL first_err idx %0d exp_f %b got_f %b required %0d %b %b",
                     fidx, fexp, fgot, o.idx, o.fexp, o.fgot);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || vec_cnt !== o.vec) begin
            fails++;
            $display("FAIL done_hold done %b busy %b vec %0d exp 1 0 %0d",
                     done, busy, vec_cnt, o.vec);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({busy, done, pass, vec_cnt, err_cnt, fidx, fexp, fgot} !== '0) begin
            fails++;
            $display("FAIL reset_state busy %b done %b vec %0d err %0d exp all 0",
                     busy, done, vec_cnt, err_cnt);
        end
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_clean_run();
        run4(-1, 5'd0, 0, 0, -1);
    endtask

    task automatic test_sum_fault();
        run4(5, 5'b00100, 0, 0, -1);
    endtask

    task automatic test_zero_vectors();
        run4(-1, 5'd0, 1, 0, -1);
        run4(3, 5'b10000, 1, 0, -1);
    endtask

    task automatic test_start_ignored();
        run4(-1, 5'd0, 0, 1, -1);
    endtask

    task automatic test_reset_mid_run();
        run4(3, 5'b00001, 0, 0, L + 7);
        @(negedge clk);
        rstn = 1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_cnt !== 16'd0) begin
            fails++;
            $display("FAIL idle_after_reset busy %b done %b vec %0d exp 0 0 0",
                     busy, done, vec_cnt);
        end
        run4(-1, 5'd0, 0, 0, -1);
    endtask

    task automatic test_latency1();
        logic [4:0] q1[$];
        logic [4:0] r;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start1 = 1;
            a = 4'd15; b = 4'd15; cin = 1;
            q1.push_back(5'(a) + 5'(b) + 5'(cin));
            @(negedge clk);
            start1 = 0;
            tests++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                fails++;
                $display("FAIL lat1_busy busy %b done %b exp 1 0", busy1, done1);
            end
            r = q1.pop_front();
            {cout1, sum1} = (k == 0) ? r : (r & 5'b01111);
            @(negedge clk);
            tests++;
            if (done1 !== 1'b1 || vec1 !== 16'd1) begin
                fails++;
                $display("FAIL lat1_done done %b vec %0d exp 1 1", done1, vec1);
            end
            if (k == 0) begin
                tests++;
                if (pass1 !== 1'b1 || err1 !== 16'd0) begin
                    fails++;
                    $display("FAIL lat1_pass pass %b err %0d exp 1 0", pass1, err1);
                end
            end else begin
                tests++;
                if (pass1 !== 1'b0 || err1 !== 16'd1 || fidx1 !== 16'd0 ||
                    fexp1 !== 5'b11111 || fgot1 !== 5'b01111) begin
                    fails++;
                    $display("FAIL lat1_mismatch pass %b err %0d idx %0d exp_f %b got_f %b required 0 1 0 11111 01111",
                             pass1, err1, fidx1, fexp1, fgot1);
                end
            end
            {cout1, sum1} = 5'd0;
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_sum_fault();
        test_zero_vectors();
        test_start_ignored();
        test_reset_mid_run();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
